seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 12, setting the operand width; product width is 2N (24 at default).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port x  input  N  unsigned multiplicand, sampled only on start acceptance.
REQ-005 The block SHALL have port y  input  N  unsigned multiplier, sampled only on start acceptance.
REQ-006 The block SHALL have port start  input  1  level request, sampled on each rising clk edge.
REQ-007 The block SHALL have port z_parallel  output  2N  registered product, feeds the shift_out stage.
REQ-008 The block SHALL have port sz  output  1  registered product-valid level; its rising edge triggers the downstream load.
REQ-009 The block SHALL have port busy  output  1  registered, high while in CALC.

Function
REQ-010 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-011 In IDLE or DONE with start=1 at a clk edge, the block SHALL latch x and y, clear the accumulator, set count=0, drive sz=0 and busy=1, and enter CALC.
REQ-012 In CALC, each edge SHALL do one shift-add step: add the multiplicand to the upper half if the multiplier LSB is 1, then shift {carry, accumulator} right by one bit.
REQ-013 The accumulator SHALL be 2N+1 bits wide so the carry of each add is never lost.
REQ-014 After exactly N CALC steps, the block SHALL load z_parallel with the 2N-bit product, drive sz=1 and busy=0, and enter DONE on the same edge.
REQ-015 Latency SHALL be N cycles from the start-accept edge to the sz rising edge (12 at default).
REQ-016 start SHALL be ignored in CALC; the latched operands are not disturbed.
REQ-017 z_parallel SHALL hold its previous value throughout CALC and change only on the REQ-014 edge.
REQ-018 sz SHALL stay high in DONE until the next accepted start, and fall on that accept edge.
REQ-019 With start held high continuously, the block SHALL restart on every DONE cycle, giving sz high for exactly one cycle per product.
REQ-020 In IDLE with start=0, the block SHALL remain in IDLE; in DONE with start=0, it SHALL remain in DONE.
REQ-021 The maximum product (2^N-1)^2 SHALL be exact, e.g. 24'hFFE001 for N=12; no truncation or saturation.

Reset
REQ-022 reset=0 SHALL asynchronously force state=IDLE, count=0, accumulator=0, z_parallel=0, sz=0 and busy=0, including when asserted mid-CALC.
REQ-023 After reset deasserts, the block SHALL take no action until the first start=1 edge, and the interrupted operation SHALL be discarded.

Configuration
REQ-024 Macro MULT_ZERO_SKIP_EN defined: if latched x==0 or y==0, the block SHALL skip CALC and go straight to DONE with z_parallel=0 and sz=1 one cycle after acceptance; busy stays 0.
REQ-025 Macro MULT_ZERO_SKIP_EN undefined: zero operands SHALL take the full N-cycle latency, with an identical product and identical interface behaviour otherwise.

Verification
REQ-026 x=3, y=5, start pulsed for one cycle -> busy high for 12 cycles; sz rises exactly 12 edges after accept; z_parallel=24'd15.
REQ-027 x=12'hFFF, y=12'hFFF -> z_parallel=24'hFFE001, sz=1; then x=12'h800, y=2 -> z_parallel=24'h001000.
REQ-028 Start x=7, y=9, then start again at CALC cycle 5 with x=1, y=1 -> second start ignored; z_parallel=24'd63 at cycle 12.
REQ-029 reset driven low at CALC cycle 6 -> z_parallel, sz and busy are 0 immediately, without waiting for a clock edge; after release, x=2, y=4 gives z_parallel=8.
REQ-030 x=0, y=12'h123 -> with MULT_ZERO_SKIP_EN: sz high 1 cycle after accept, z_parallel=0; without it: sz high 12 cycles after accept, z_parallel=0.
REQ-031 start held high with x=10, y=10 -> sz pulses high for 1 cycle every 13 cycles; z_parallel=24'd100 at each pulse.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned N x N shift-add multiplier, one partial-product step per clock.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   reset      - asynchronous, active-low reset
//   x, y       - multiplicand / multiplier, sampled only when a start is accepted
//   start      - level request, accepted in IDLE or DONE
//   z_parallel - registered 2N-bit product, updated only when a product completes
//   sz         - registered product-valid level, high in DONE
//   busy       - registered, high while in CALC
//
// Optional feature: define MULT_ZERO_SKIP_EN to finish a zero-operand product in one
// cycle (busy never rises). Without it every product takes the full N cycles.
module seq_multiplier #(
  parameter int unsigned N = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic           start,
  output logic [2*N-1:0] z_parallel,
  output logic           sz,
  output logic           busy
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [N-1:0]    mcand_q, mcand_d;
  // {carry, upper partial product, remaining multiplier bits}
  logic [2*N:0]    acc_q, acc_d;
  logic [2*N-1:0]  z_q, z_d;
  logic            sz_q, sz_d;
  logic            busy_q, busy_d;
`ifdef MULT_ZERO_SKIP_EN
  logic            zero_q, zero_d;
`endif

  logic [N:0]      sum;
  logic [2*N:0]    acc_add;
  logic [2*N:0]    acc_step;

  // One shift-add step; the add carry lands in sum[N] and is kept by the shift.
  always_comb begin
    sum      = {1'b0, acc_q[2*N-1:N]};
    if (acc_q[0]) begin
      sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q};
    end
    acc_add  = {sum, acc_q[N-1:0]};
    acc_step = acc_add >> 1;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    z_d     = z_q;
    sz_d    = sz_q;
    busy_d  = busy_q;
`ifdef MULT_ZERO_SKIP_EN
    zero_d  = zero_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mcand_d = x;
          acc_d   = {{(N + 1){1'b0}}, y};
          count_d = '0;
          sz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = StCalc;
`ifdef MULT_ZERO_SKIP_EN
          zero_d  = (x == '0) || (y == '0);
          busy_d  = !((x == '0) || (y == '0));
`endif
        end
      end
      StCalc: begin
`ifdef MULT_ZERO_SKIP_EN
        if (zero_q) begin
          z_d     = '0;
          sz_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else
`endif
        begin
          acc_d   = acc_step;
          count_d = count_q + 1'b1;
          // Last step: publish the product on the same edge it is formed.
          if (count_q == CntW'(N - 1)) begin
            z_d     = acc_step[2*N-1:0];
            sz_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      sz_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULT_ZERO_SKIP_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      sz_q    <= sz_d;
      busy_q  <= busy_d;
`ifdef MULT_ZERO_SKIP_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign z_parallel = z_q;
  assign sz         = sz_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int N = 12;
  localparam int Lat = 12;
`ifdef MULT_ZERO_SKIP_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = 12;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   x = '0;
  logic [N-1:0]   y = '0;
  logic           start = 1'b0;
  logic [2*N-1:0] z_parallel;
  logic           sz;
  logic           busy;

  seq_multiplier #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .start      (start),
    .z_parallel (z_parallel),
    .sz         (sz),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*N-1:0] prod;
    int             due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: on every sz rising edge pop the scoreboard and compare product, timing, busy.
  logic sz_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      sz_prev <= 1'b0;
    end else begin
      sz_prev <= sz;
      if (sz && !sz_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sz", 64'(sz), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", 64'(z_parallel), 64'(e.prod));
          check("sz_rise_cycle", 64'(cyc), 64'(e.due));
          check("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
  endtask

  // Issue a one-cycle start pulse and queue the expected product.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] prod, input int lat, input logic busy_exp);
    exp_t e;
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    e.prod = prod;
    e.due = cyc + 1 + lat;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(busy_exp));
  endtask

  initial begin
    exp_t e;
    int base;
    int i;
    // Reset state
    #1;
    check("rst_z", 64'(z_parallel), 64'(0));
    check("rst_sz", 64'(sz), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_sz", 64'(sz), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // Basic product and latency
    run_op(12'd3, 12'd5, 24'd15, Lat, 1'b1);
    drain();
    // Maximum product, then a carry-heavy power of two
    run_op(12'hFFF, 12'hFFF, 24'hFFE001, Lat, 1'b1);
    drain();
    check("sz_holds_in_done", 64'(sz), 64'(1));
    run_op(12'h800, 12'd2, 24'h001000, Lat, 1'b1);
    repeat (4) @(negedge clk);
    check("z_held_in_calc", 64'(z_parallel), 64'(24'hFFE001));
    check("sz_low_in_calc", 64'(sz), 64'(0));
    drain();

    // Second start during CALC is ignored
    run_op(12'd7, 12'd9, 24'd63, Lat, 1'b1);
    repeat (3) @(negedge clk);
    x = 12'd1;
    y = 12'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("no_extra_product", 64'(z_parallel), 64'(24'd63));

    // Asynchronous reset mid-CALC discards the operation
    run_op(12'd5, 12'd6, 24'd30, Lat, 1'b1);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midcalc_rst_z", 64'(z_parallel), 64'(0));
    check("midcalc_rst_sz", 64'(sz), 64'(0));
    check("midcalc_rst_busy", 64'(busy), 64'(0));
    e = exp_q.pop_back();
    @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    check("post_rst_idle_sz", 64'(sz), 64'(0));
    run_op(12'd2, 12'd4, 24'd8, Lat, 1'b1);
    drain();

    // Zero operand
    run_op(12'd0, 12'h123, 24'd0, ZeroLat, (ZeroLat != 1));
    drain();

    // Start held high: back-to-back products every Lat+1 cycles
    @(negedge clk);
    x = 12'd10;
    y = 12'd10;
    start = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.prod = 24'd100;
      e.due = base + Lat + k * (Lat + 1);
      exp_q.push_back(e);
    end
    i = 0;
    while (cyc < base + Lat + 2 * (Lat + 1) && i < 200) begin
      @(negedge clk);
      i++;
    end
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("held_final_sz", 64'(sz), 64'(1));
    check("held_final_z", 64'(z_parallel), 64'(24'd100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
